// File: rtl/parc_core_rob_rename_table_if.sv
// Decode/ROB-facing signal bundle of the rename table.
// master drives decode requests and ROB responses; slave is the table itself.
interface parc_core_rob_rename_table_if #(
  parameter int SLOT_BITS = 4
);
  logic                 dec_alloc_val;
  logic                 dec_alloc_rdy;
  logic [4:0]           dec_alloc_dst;
  logic                 rob_alloc_req_val;
  logic                 rob_alloc_req_rdy;
  logic [4:0]           rob_alloc_req_preg;
  logic [SLOT_BITS-1:0] rob_alloc_resp_slot;
  logic                 rob_fill_val;
  logic [SLOT_BITS-1:0] rob_fill_slot;
  logic                 rob_commit_wen;
  logic [SLOT_BITS-1:0] rob_commit_slot;
  logic [4:0]           rob_commit_rf_waddr;
  logic                 flush;
  logic [4:0]           dec_rs_addr;
  logic [4:0]           dec_rt_addr;
  logic                 rs_busy;
  logic [SLOT_BITS-1:0] rs_slot;
  logic                 rs_done;
  logic                 rt_busy;
  logic [SLOT_BITS-1:0] rt_slot;
  logic                 rt_done;

  modport master (
    output dec_alloc_val, dec_alloc_dst, rob_alloc_req_rdy, rob_alloc_resp_slot,
           rob_fill_val, rob_fill_slot, rob_commit_wen, rob_commit_slot,
           rob_commit_rf_waddr, flush, dec_rs_addr, dec_rt_addr,
    input  dec_alloc_rdy, rob_alloc_req_val, rob_alloc_req_preg,
           rs_busy, rs_slot, rs_done, rt_busy, rt_slot, rt_done
  );

  modport slave (
    input  dec_alloc_val, dec_alloc_dst, rob_alloc_req_rdy, rob_alloc_resp_slot,
           rob_fill_val, rob_fill_slot, rob_commit_wen, rob_commit_slot,
           rob_commit_rf_waddr, flush, dec_rs_addr, dec_rt_addr,
    output dec_alloc_rdy, rob_alloc_req_val, rob_alloc_req_preg,
           rs_busy, rs_slot, rs_done, rt_busy, rt_slot, rt_done
  );
endinterface

// File: rtl/parc_core_rob_rename_table.sv
// Architectural-register -> ROB-slot rename table with per-slot completion tracking.
// Handshake and lookups are combinational; mapping/done updates land on the next edge.
module parc_core_rob_rename_table #(
  parameter int NUM_SLOTS = 16,
  parameter int SLOT_BITS = 4,
  parameter int NUM_REGS  = 32
) (
  input logic clk,
  input logic reset,
  parc_core_rob_rename_table_if.slave bus
);

  logic [NUM_REGS-1:0]  map_busy_q, map_busy_d;
  logic [SLOT_BITS-1:0] map_slot_q [NUM_REGS];
  logic [SLOT_BITS-1:0] map_slot_d [NUM_REGS];
  logic [NUM_SLOTS-1:0] slot_done_q, slot_done_d;

  logic fire;

  assign bus.rob_alloc_req_val  = bus.dec_alloc_val & ~bus.flush;
  assign bus.dec_alloc_rdy      = bus.rob_alloc_req_rdy & ~bus.flush;
  assign bus.rob_alloc_req_preg = bus.dec_alloc_dst;
  assign fire                   = bus.dec_alloc_val & bus.dec_alloc_rdy;

  // Lookups read pre-edge state; a same-cycle fill is bypassed into done.
  logic [4:0]           lk_addr [2];
  logic                 lk_busy [2];
  logic [SLOT_BITS-1:0] lk_slot [2];
  logic                 lk_done [2];

  assign lk_addr[0] = bus.dec_rs_addr;
  assign lk_addr[1] = bus.dec_rt_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_busy[p] = map_busy_q[lk_addr[p]] && (lk_addr[p] != 5'd0);
      lk_slot[p] = lk_busy[p] ? map_slot_q[lk_addr[p]] : '0;
      lk_done[p] = lk_busy[p] &&
                   (slot_done_q[lk_slot[p]] ||
                    (bus.rob_fill_val && (bus.rob_fill_slot == lk_slot[p])));
    end
  end

  assign bus.rs_busy = lk_busy[0];
  assign bus.rs_slot = lk_slot[0];
  assign bus.rs_done = lk_done[0];
  assign bus.rt_busy = lk_busy[1];
  assign bus.rt_slot = lk_slot[1];
  assign bus.rt_done = lk_done[1];

  // Commit and fill are applied first so a same-cycle alloc overrides both.
  always_comb begin
    map_busy_d  = map_busy_q;
    map_slot_d  = map_slot_q;
    slot_done_d = slot_done_q;
    if (bus.flush) begin
      map_busy_d  = '0;
      slot_done_d = '0;
    end else begin
      if (bus.rob_commit_wen && map_busy_q[bus.rob_commit_rf_waddr] &&
          (map_slot_q[bus.rob_commit_rf_waddr] == bus.rob_commit_slot)) begin
        map_busy_d[bus.rob_commit_rf_waddr] = 1'b0;
      end
      if (bus.rob_fill_val) begin
        slot_done_d[bus.rob_fill_slot] = 1'b1;
      end
      if (fire) begin
        slot_done_d[bus.rob_alloc_resp_slot] = 1'b0;
        if (bus.dec_alloc_dst != 5'd0) begin
          map_busy_d[bus.dec_alloc_dst] = 1'b1;
          map_slot_d[bus.dec_alloc_dst] = bus.rob_alloc_resp_slot;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      map_busy_q  <= '0;
      slot_done_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        map_slot_q[r] <= '0;
      end
    end else begin
      map_busy_q  <= map_busy_d;
      slot_done_q <= slot_done_d;
      map_slot_q  <= map_slot_d;
    end
  end

endmodule

// File: tb/tb_parc_core_rob_rename_table.sv
// Rename table bench: directed cases plus random traffic, checked by a queue-based
// scoreboard against an owner-array reference model.
module tb_parc_core_rob_rename_table;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parc_core_rob_rename_table_if #(.SLOT_BITS(4)) bus ();

  parc_core_rob_rename_table #(.NUM_SLOTS(16), .SLOT_BITS(4), .NUM_REGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rdy;
    logic       req_val;
    logic [4:0] preg;
    logic       rs_busy;
    logic [3:0] rs_slot;
    logic       rs_done;
    logic       rt_busy;
    logic [3:0] rt_slot;
    logic       rt_done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: owning slot per register (-1 = free), completion per slot.
  int owner [32];
  bit done_m [16];

  // Stimulus fields for the next cycle.
  bit       s_reset, s_val, s_rdy, s_fv, s_cw, s_flush;
  bit [4:0] s_dst, s_cwa, s_rs, s_rt;
  bit [3:0] s_resp, s_fs, s_cs;

  task automatic clr();
    s_reset = 0; s_val = 0; s_rdy = 1; s_fv = 0; s_cw = 0; s_flush = 0;
    s_dst = 0; s_cwa = 0; s_resp = 0; s_fs = 0; s_cs = 0;
  endtask

  task automatic model_lookup(input bit [4:0] a, output logic b, output logic [3:0] sl,
                              output logic d);
    b  = (a != 0) && (owner[a] >= 0);
    sl = b ? 4'(owner[a]) : 4'd0;
    d  = b && (done_m[sl] || (s_fv && s_fs == sl));
  endtask

  // Drive one cycle at negedge, push its expected outputs, then advance the model.
  task automatic cyc(input bit push = 1);
    exp_t e;
    int   own_n [32];
    bit   done_n [16];
    bit   fire;
    @(negedge clk);
    reset                   = s_reset;
    bus.dec_alloc_val       = s_val;
    bus.dec_alloc_dst       = s_dst;
    bus.rob_alloc_req_rdy   = s_rdy;
    bus.rob_alloc_resp_slot = s_resp;
    bus.rob_fill_val        = s_fv;
    bus.rob_fill_slot       = s_fs;
    bus.rob_commit_wen      = s_cw;
    bus.rob_commit_slot     = s_cs;
    bus.rob_commit_rf_waddr = s_cwa;
    bus.flush               = s_flush;
    bus.dec_rs_addr         = s_rs;
    bus.dec_rt_addr         = s_rt;

    fire      = s_val && s_rdy && !s_flush;
    e.rdy     = s_rdy && !s_flush;
    e.req_val = s_val && !s_flush;
    e.preg    = s_dst;
    model_lookup(s_rs, e.rs_busy, e.rs_slot, e.rs_done);
    model_lookup(s_rt, e.rt_busy, e.rt_slot, e.rt_done);
    if (push) exp_q.push_back(e);

    own_n  = owner;
    done_n = done_m;
    if (s_reset || s_flush) begin
      foreach (own_n[r])  own_n[r]  = -1;
      foreach (done_n[k]) done_n[k] = 0;
    end else begin
      if (s_cw && owner[s_cwa] == int'(s_cs)) own_n[s_cwa] = -1;
      if (s_fv) done_n[s_fs] = 1;
      if (fire) begin
        done_n[s_resp] = 0;
        if (s_dst != 0) own_n[s_dst] = int'(s_resp);
      end
    end
    owner  = own_n;
    done_m = done_n;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dec_alloc_rdy",      8'(bus.dec_alloc_rdy),      8'(e.rdy));
        chk("rob_alloc_req_val",  8'(bus.rob_alloc_req_val),  8'(e.req_val));
        chk("rob_alloc_req_preg", 8'(bus.rob_alloc_req_preg), 8'(e.preg));
        chk("rs_busy", 8'(bus.rs_busy), 8'(e.rs_busy));
        chk("rs_slot", 8'(bus.rs_slot), 8'(e.rs_slot));
        chk("rs_done", 8'(bus.rs_done), 8'(e.rs_done));
        chk("rt_busy", 8'(bus.rt_busy), 8'(e.rt_busy));
        chk("rt_slot", 8'(bus.rt_slot), 8'(e.rt_slot));
        chk("rt_done", 8'(bus.rt_done), 8'(e.rt_done));
      end
    end
  end

  task automatic alloc(input bit [4:0] d, input bit [3:0] sl);
    clr(); s_val = 1; s_dst = d; s_resp = sl; cyc();
  endtask

  initial begin
    int tail = 0;
    int budget;
    foreach (owner[r])  owner[r]  = -1;
    foreach (done_m[k]) done_m[k] = 0;
    s_rs = 5; s_rt = 0;
    clr(); s_reset = 1;
    cyc(0); cyc(0);

    // Reset state, then basic map / fill / commit on r5.
    clr(); cyc();
    alloc(5, 3);
    clr(); cyc();
    clr(); s_fv = 1; s_fs = 3; cyc();
    clr(); cyc();
    clr(); s_cw = 1; s_cs = 3; s_cwa = 5; cyc();
    clr(); cyc();

    // Stale commit leaves the newer mapping in place.
    s_rs = 7; s_rt = 5;
    alloc(7, 2);
    alloc(7, 4);
    clr(); s_cw = 1; s_cs = 2; s_cwa = 7; cyc();
    clr(); cyc();
    clr(); s_cw = 1; s_cs = 4; s_cwa = 7; cyc();
    clr(); cyc();

    // Same-cycle alloc and commit on r9: alloc wins.
    s_rs = 9; s_rt = 9;
    alloc(9, 1);
    clr(); s_val = 1; s_dst = 9; s_resp = 6; s_cw = 1; s_cs = 1; s_cwa = 9; cyc();
    clr(); cyc();

    // ROB full: no state change; then r0 alloc gets no mapping.
    s_rs = 11; s_rt = 0;
    clr(); s_val = 1; s_dst = 11; s_resp = 8; s_rdy = 0; cyc();
    clr(); cyc();
    alloc(0, 9);
    clr(); cyc();

    // Flush with three live mappings and a pending alloc.
    alloc(1, 10); alloc(2, 11); alloc(3, 12);
    clr(); s_fv = 1; s_fs = 10; cyc();
    s_rs = 1; s_rt = 3;
    clr(); s_flush = 1; s_val = 1; s_dst = 4; s_resp = 13; cyc();
    clr(); cyc();
    s_rs = 2; clr(); cyc();

    // Random traffic over a small register window to force collisions.
    for (int i = 0; i < 600; i++) begin
      int r;
      clr();
      s_val   = ($urandom_range(0, 9) < 6);
      s_rdy   = ($urandom_range(0, 9) < 8);
      s_dst   = 5'($urandom_range(0, 7));
      s_resp  = 4'(tail);
      s_fv    = ($urandom_range(0, 9) < 4);
      s_fs    = 4'($urandom_range(0, 15));
      s_flush = ($urandom_range(0, 99) < 3);
      s_reset = ($urandom_range(0, 199) < 1);
      s_rs    = 5'($urandom_range(0, 7));
      s_rt    = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 4) begin
        r = $urandom_range(1, 7);
        s_cw  = 1;
        s_cwa = 5'(r);
        s_cs  = (owner[r] >= 0 && $urandom_range(0, 3) != 0) ? 4'(owner[r])
                                                             : 4'($urandom_range(0, 15));
      end
      if (s_val && s_rdy && !s_flush) tail = (tail + 1) % 16;
      cyc();
    end

    clr(); cyc(0);
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #5;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parc_core_rob_rename_table.md
# parc_core_rob_rename_table

Decode-side companion to the core reorder buffer. It issues allocation requests into the ROB on behalf of the decode stage and records which ROB slot will produce each architectural register. It also tracks per-slot completion so decode can resolve source operands (busy / slot / done) for bypass and stall decisions. Mappings retire when the ROB reports commits. The table sits between the decode stage and the ROB alloc/fill/commit interfaces.

## Interface
- NUM_SLOTS, 16, ROB depth; must match the ROB.
- SLOT_BITS, 4, log2(NUM_SLOTS).
- NUM_REGS, 32, architectural registers; r0 is never mapped.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dec_alloc_val  in  1  decode wants to allocate a ROB entry
- dec_alloc_rdy  out  1  allocation accepted this cycle if val is high
- dec_alloc_dst  in  5  destination register of the allocating instruction
- rob_alloc_req_val  out  1  ROB allocation request
- rob_alloc_req_rdy  in  1  ROB not full
- rob_alloc_req_preg  out  5  destination register sent to the ROB
- rob_alloc_resp_slot  in  SLOT_BITS  slot the ROB assigns this cycle
- rob_fill_val  in  1  a result for rob_fill_slot completed
- rob_fill_slot  in  SLOT_BITS  completed slot
- rob_commit_wen  in  1  ROB commits its head entry
- rob_commit_slot  in  SLOT_BITS  committed slot
- rob_commit_rf_waddr  in  5  destination register of the committed entry
- flush  in  1  discard all mappings (mispredict recovery)
- dec_rs_addr, dec_rt_addr  in  5 each  source register lookups
- rs_busy, rt_busy  out  1 each  source value is owned by an uncommitted ROB entry
- rs_slot, rt_slot  out  SLOT_BITS each  owning slot; 0 when not busy
- rs_done, rt_done  out  1 each  owning slot has completed; 0 when not busy

## Operation
- State:
  - map_busy[NUM_REGS] and map_slot[NUM_REGS][SLOT_BITS].
  - slot_done[NUM_SLOTS].
  - No FSM; all updates are per-cycle register writes.
- Handshake passthrough (combinational):
  - rob_alloc_req_val = dec_alloc_val & !flush.
  - dec_alloc_rdy = rob_alloc_req_rdy & !flush.
  - rob_alloc_req_preg = dec_alloc_dst.
  - fire = dec_alloc_val & dec_alloc_rdy.
- On fire:
  - slot_done[rob_alloc_resp_slot] <= 0.
  - If dec_alloc_dst != 0: map_busy[dst] <= 1 and map_slot[dst] <= rob_alloc_resp_slot.
  - r0 still allocates a ROB entry, but gets no mapping.
- Fill: rob_fill_val sets slot_done[rob_fill_slot] <= 1.
- Commit: if rob_commit_wen & map_busy[waddr] & (map_slot[waddr] == rob_commit_slot), then map_busy[waddr] <= 0. A stale commit (the register has since been remapped) leaves the mapping untouched.
- Lookup (combinational from current state; applies to rs and rt independently):
  - busy = map_busy[addr] & (addr != 0).
  - slot = busy ? map_slot[addr] : 0.
  - done = busy & (slot_done[slot] | (rob_fill_val & rob_fill_slot == slot)). This same-cycle fill bypass is required.
- Priority within one cycle:
  - reset > flush > (alloc, fill, commit).
  - Alloc and commit on the same register: alloc's new mapping wins.
  - Alloc and fill on the same slot: alloc wins (done cleared). This is a protocol violation, but the behaviour is defined.
  - Fill and commit on the same slot: both apply.
- Flush: clears all map_busy and slot_done next edge; no allocation fires that cycle.
- Wrap-around: slots are opaque tags; reuse after 16 allocations is handled by clear-on-alloc.

## Timing
- Reset state: map_busy = 0, map_slot = 0, slot_done = 0. Consequently rs/rt_busy = 0, rs/rt_slot = 0, rs/rt_done = 0.
- Reset mid-operation clears all state regardless of other inputs.
- Handshake outputs and lookup outputs are combinational and follow inputs in the same cycle.
- A lookup sees state from before this cycle's edge. An instruction reading and writing the same register therefore gets its producer's mapping, not its own.
- A mapping is visible to lookups 1 cycle after fire.
- Commit removes the mapping 1 cycle after rob_commit_wen.
- slot_done is visible combinationally in the fill cycle and registered from the next cycle.
- ROB full: dec_alloc_rdy = 0 and no state changes from alloc.

## Test plan
- Reset, then look up r5 -> busy=0, slot=0, done=0.
  - Fire alloc dst=5 with resp_slot=3.
  - Next cycle, look up r5 -> busy=1, slot=3, done=0.
- Fill slot 3 -> done=1 in the same cycle (bypass) and after the edge.
  - Commit (slot 3, waddr 5) -> busy=0 the next cycle.
- Alloc r7 -> slot 2, then alloc r7 -> slot 4.
  - Commit (slot 2, waddr 7) -> r7 stays busy with slot=4.
  - Commit (slot 4, waddr 7) -> r7 busy=0.
- Same-cycle alloc r9 -> slot 6 together with commit (slot 1, waddr 9), where r9 was mapped to slot 1 -> r9 busy=1, slot=6.
- rob_alloc_req_rdy=0 with dec_alloc_val=1 -> dec_alloc_rdy=0, table unchanged.
  - Alloc dst=0 -> rob_alloc_req_val=1, r0 lookup stays busy=0.
- After 3 mappings are live, assert flush with dec_alloc_val=1 -> rob_alloc_req_val=0. The next cycle, all lookups show busy=0 and done=0.
